// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
package seq_det_pkg;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;
   localparam logic [DEF_PAT_W-1:0] DEF_PAT = 4'b1101;

   // Fill counter must hold 0..pat_w-1.
   function automatic int fill_w(input int pat_w);
      return (pat_w <= 2) ? 1 : $clog2(pat_w);
   endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is high at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   assign sat = &count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && !sat)
         count <= count + W'(1);
   end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: Mealy match flag on the bit that completes the
// programmable pattern, with overlap control and a saturating match counter.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter int               CNT_W   = DEF_CNT_W,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i,
   input  logic             i_valid,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap_en,
   input  logic             clear,
   output logic             o,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int             FW       = fill_w(PAT_W);
   localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

   logic [PAT_W-1:0] pattern;
   logic [PAT_W-2:0] history;
   logic [FW-1:0]    fill;
   logic [PAT_W-1:0] window;
   logic             flush;

   // The candidate window includes the live input bit, so o has no register
   // between i and the match decision.
   assign window = {history, i};
   assign flush  = clear | pat_load;
   assign o      = i_valid & ~flush & (fill == FILL_MAX) & (window == pattern);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pattern <= RST_PAT;
         history <= '0;
         fill    <= '0;
      end else begin
         if (pat_load)
            pattern <= pat_in;
         if (flush) begin
            history <= '0;
            fill    <= '0;
         end else if (i_valid) begin
            history <= window[PAT_W-2:0];
            // Non-overlap restarts the fill so the next match needs PAT_W fresh bits.
            if (o && !overlap_en)
               fill <= '0;
            else if (fill != FILL_MAX)
               fill <= fill + FW'(1);
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (clear),
      .inc   (o),
      .count (match_count),
      .sat   (count_sat)
   );

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default, 2-bit-counter and 8-bit-pattern instances.
module tb_seq_detector;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Instance 0: defaults
   logic       i0 = 0, v0 = 0, pl0 = 0, ov0 = 0, clr0 = 0;
   logic [3:0] pin0 = '0;
   logic       o0, sat0;
   logic [7:0] cnt0;

   // Instance 1: 2-bit counter, pattern 1111
   logic       i1 = 0, v1 = 0, pl1 = 0, ov1 = 0, clr1 = 0;
   logic [3:0] pin1 = '0;
   logic       o1, sat1;
   logic [1:0] cnt1;

   // Instance 2: 8-bit pattern A5
   logic       i2 = 0, v2 = 0, pl2 = 0, ov2 = 0, clr2 = 0;
   logic [7:0] pin2 = '0;
   logic       o2, sat2;
   logic [7:0] cnt2;

   seq_detector dut0 (
      .clk(clk), .n_rst(n_rst), .i(i0), .i_valid(v0), .pat_load(pl0), .pat_in(pin0),
      .overlap_en(ov0), .clear(clr0), .o(o0), .match_count(cnt0), .count_sat(sat0)
   );

   seq_detector #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1111)) dut1 (
      .clk(clk), .n_rst(n_rst), .i(i1), .i_valid(v1), .pat_load(pl1), .pat_in(pin1),
      .overlap_en(ov1), .clear(clr1), .o(o1), .match_count(cnt1), .count_sat(sat1)
   );

   seq_detector #(.PAT_W(8), .CNT_W(8), .RST_PAT(8'hA5)) dut2 (
      .clk(clk), .n_rst(n_rst), .i(i2), .i_valid(v2), .pat_load(pl2), .pat_in(pin2),
      .overlap_en(ov2), .clear(clr2), .o(o2), .match_count(cnt2), .count_sat(sat2)
   );

   // Drivers: change inputs at the falling edge, return 1 time unit later
   // so the Mealy output can be sampled before the next rising edge.
   task automatic drv0(input logic b, input logic v, input logic pl = 1'b0, input logic cl = 1'b0);
      @(negedge clk);
      i0 = b; v0 = v; pl0 = pl; clr0 = cl;
      #1;
   endtask

   task automatic drv1(input logic b, input logic v, input logic cl = 1'b0);
      @(negedge clk);
      i1 = b; v1 = v; clr1 = cl;
      #1;
   endtask

   task automatic drv2(input logic b, input logic v, input logic cl = 1'b0);
      @(negedge clk);
      i2 = b; v2 = v; clr2 = cl;
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      i0 = 1; v0 = 1; ov0 = 1;
      i1 = 1; v1 = 1; ov1 = 1;
      i2 = 1; v2 = 1; ov2 = 1;
      @(posedge clk);
      @(negedge clk);
      vectors++; if (o0 !== 1'b0) begin miscompares++; $display("FAIL reset_o0 got %b want 0", o0); end
      vectors++; if (cnt0 !== 8'd0) begin miscompares++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
      vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("FAIL reset_sat0 got %b want 0", sat0); end
      vectors++; if (o1 !== 1'b0 || cnt1 !== 2'd0 || sat1 !== 1'b0) begin
         miscompares++; $display("FAIL reset_dut1 got o=%b cnt=%0d sat=%b want 0/0/0", o1, cnt1, sat1); end
      vectors++; if (o2 !== 1'b0) begin miscompares++; $display("FAIL reset_o2 got %b want 0", o2); end
      n_rst = 1'b1;
      v1 = 0; v2 = 0;
      drv0(1, 1);
      vectors++; if (o0 !== 1'b0) begin miscompares++; $display("FAIL reset_release_o got %b want 0", o0); end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd0) begin miscompares++; $display("FAIL reset_release_cnt got %0d want 0", cnt0); end
   endtask

   task automatic test_overlap();
      logic [6:0] s, e;
      s = 7'b1101101;
      e = 7'b0001001;
      ov0 = 1;
      drv0(0, 0, 0, 1);
      for (int k = 0; k < 7; k++) begin
         drv0(s[6-k], 1);
         vectors++;
         if (o0 !== e[6-k]) begin miscompares++; $display("FAIL overlap_o bit%0d got %b want %b", k+1, o0, e[6-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd2) begin miscompares++; $display("FAIL overlap_cnt got %0d want 2", cnt0); end
   endtask

   task automatic test_non_overlap();
      logic [6:0] s, e;
      logic [9:0] b, v, ex;
      s = 7'b1101101;
      e = 7'b0001000;
      ov0 = 0;
      drv0(0, 0, 0, 1);
      for (int k = 0; k < 7; k++) begin
         drv0(s[6-k], 1);
         vectors++;
         if (o0 !== e[6-k]) begin miscompares++; $display("FAIL nonovl_o bit%0d got %b want %b", k+1, o0, e[6-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd1) begin miscompares++; $display("FAIL nonovl_cnt got %0d want 1", cnt0); end
      // 11011101 with i_valid=0 gaps carrying i=1
      b  = 10'b1101111101;
      v  = 10'b1110110111;
      ex = 10'b0000100001;
      drv0(0, 0, 0, 1);
      for (int k = 0; k < 10; k++) begin
         drv0(b[9-k], v[9-k]);
         vectors++;
         if (o0 !== ex[9-k]) begin miscompares++; $display("FAIL nonovl_gap_o step%0d got %b want %b", k, o0, ex[9-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd2) begin miscompares++; $display("FAIL nonovl_gap_cnt got %0d want 2", cnt0); end
   endtask

   task automatic test_mid_reset();
      logic [6:0] s;
      logic [3:0] t, e;
      s = 7'b1101110;
      ov0 = 1;
      drv0(0, 0, 0, 1);
      for (int k = 0; k < 7; k++) drv0(s[6-k], 1);
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd1) begin miscompares++; $display("FAIL midrst_pre_cnt got %0d want 1", cnt0); end
      @(negedge clk);
      n_rst = 1'b0;
      #2;
      vectors++; if (cnt0 !== 8'd0) begin miscompares++; $display("FAIL midrst_async_cnt got %0d want 0", cnt0); end
      n_rst = 1'b1;
      t = 4'b1101;
      e = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         drv0(t[3-k], 1);
         vectors++;
         if (o0 !== e[3-k]) begin miscompares++; $display("FAIL midrst_o bit%0d got %b want %b", k+1, o0, e[3-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd1) begin miscompares++; $display("FAIL midrst_cnt got %0d want 1", cnt0); end
   endtask

   task automatic test_pat_load();
      logic [3:0] t, e;
      ov0 = 1;
      drv0(0, 0, 0, 1);
      t = 4'b1101; e = 4'b0001;
      for (int k = 0; k < 4; k++) drv0(t[3-k], 1);
      drv0(1, 1);
      drv0(1, 1);
      pin0 = 4'b0110;
      drv0(0, 1, 1, 0);
      vectors++; if (o0 !== 1'b0) begin miscompares++; $display("FAIL patload_o got %b want 0", o0); end
      t = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         drv0(t[3-k], 1);
         vectors++;
         if (o0 !== e[3-k]) begin miscompares++; $display("FAIL patload_new_o bit%0d got %b want %b", k+1, o0, e[3-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd2) begin miscompares++; $display("FAIL patload_cnt got %0d want 2", cnt0); end
      // set up history 011 so i=0 would complete 0110, then clear+load together
      drv0(1, 1);
      drv0(1, 1);
      pin0 = 4'b1001;
      drv0(0, 1, 1, 1);
      vectors++; if (o0 !== 1'b0) begin miscompares++; $display("FAIL clrload_o got %b want 0", o0); end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd0 || sat0 !== 1'b0) begin
         miscompares++; $display("FAIL clrload_cnt got %0d sat %b want 0 0", cnt0, sat0); end
      t = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         drv0(t[3-k], 1);
         vectors++;
         if (o0 !== e[3-k]) begin miscompares++; $display("FAIL clrload_new_o bit%0d got %b want %b", k+1, o0, e[3-k]); end
      end
      drv0(0, 0);
      vectors++; if (cnt0 !== 8'd1) begin miscompares++; $display("FAIL clrload_cnt2 got %0d want 1", cnt0); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      logic       exp_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      ov1 = 1;
      drv1(0, 0, 1);
      for (int k = 1; k <= 7; k++) begin
         drv1(1, 1);
         vectors++;
         if (o1 !== (k >= 4)) begin miscompares++; $display("FAIL sat_o bit%0d got %b want %b", k, o1, (k >= 4)); end
         @(posedge clk);
         #1;
         if (k >= 4) begin
            vectors++;
            if (cnt1 !== exp_cnt[k-4] || sat1 !== exp_sat[k-4]) begin
               miscompares++;
               $display("FAIL sat_cnt bit%0d got %0d/%b want %0d/%b", k, cnt1, sat1, exp_cnt[k-4], exp_sat[k-4]);
            end
         end
      end
      drv1(1, 1, 1);
      vectors++; if (o1 !== 1'b0) begin miscompares++; $display("FAIL sat_clear_o got %b want 0", o1); end
      drv1(0, 0);
      vectors++; if (cnt1 !== 2'd0 || sat1 !== 1'b0) begin
         miscompares++; $display("FAIL sat_clear got %0d/%b want 0/0", cnt1, sat1); end
   endtask

   task automatic test_param();
      logic [15:0] s, e;
      logic [7:0]  a;
      s = 16'hA5A5;
      e = 16'h0101;
      for (int m = 0; m < 2; m++) begin
         ov2 = (m == 1);
         drv2(0, 0, 1);
         for (int k = 0; k < 16; k++) begin
            drv2(s[15-k], 1);
            vectors++;
            if (o2 !== e[15-k]) begin miscompares++; $display("FAIL param_o ovl=%0d bit%0d got %b want %b", m, k+1, o2, e[15-k]); end
         end
         drv2(0, 0);
         vectors++; if (cnt2 !== 8'd2) begin miscompares++; $display("FAIL param_cnt ovl=%0d got %0d want 2", m, cnt2); end
      end
      a = 8'hA4;
      drv2(0, 0, 1);
      for (int k = 0; k < 8; k++) begin
         drv2(a[7-k], 1);
         vectors++;
         if (o2 !== 1'b0) begin miscompares++; $display("FAIL param_a4_o bit%0d got %b want 0", k+1, o2); end
      end
      drv2(0, 0);
      vectors++; if (cnt2 !== 8'd0) begin miscompares++; $display("FAIL param_a4_cnt got %0d want 0", cnt2); end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_mid_reset();
      test_pat_load();
      test_saturation();
      test_param();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width in bits.
REQ-003 SHALL have parameter RST_PAT, default 4'b1101 (PAT_W bits), pattern loaded at reset.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i  input  1  serial data bit, sampled only when i_valid=1.
REQ-007 SHALL have port i_valid  input  1  qualifies i for the current cycle.
REQ-008 SHALL have port pat_load  input  1  loads pat_in into the pattern register at the next edge.
REQ-009 SHALL have port pat_in  input  PAT_W  new pattern, MSB is the first bit received.
REQ-010 SHALL have port overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port clear  input  1  synchronous clear of history, fill count and match count.
REQ-012 SHALL have port o  output  1  Mealy match flag for the current input bit.
REQ-013 SHALL have port match_count  output  CNT_W  number of matches since reset/clear.
REQ-014 SHALL have port count_sat  output  1  high while match_count is at all-ones.

Function
REQ-015 SHALL hold a PAT_W-1 bit history shift register; each i_valid=1 edge shifts i into its LSB.
REQ-016 SHALL hold a fill counter, 0..PAT_W-1 saturating, incremented on each accepted bit.
REQ-017 SHALL assert o combinationally when i_valid=1, fill=PAT_W-1, {history, i}==pattern, pat_load=0, clear=0; zero-cycle latency, no register between i and o.
REQ-018 SHALL deassert o whenever i_valid=0.
REQ-019 In overlap mode (overlap_en=1), SHALL leave fill saturated after a match, so shared suffix/prefix bits count toward the next match.
REQ-020 In non-overlap mode, SHALL reset fill to 0 at the edge where o=1, so the next match requires PAT_W fresh bits.
REQ-021 SHALL sample overlap_en every cycle; a change affects only matches at or after that edge.
REQ-022 SHALL increment match_count at every edge where o=1.
REQ-023 SHALL saturate match_count at 2^CNT_W-1 with no wrap; count_sat = (match_count == all-ones).
REQ-024 On pat_load=1, SHALL load pat_in, clear history and fill, force o=0 and discard i that cycle; match_count retained.
REQ-025 On clear=1, SHALL clear history, fill and match_count, force o=0 and discard i that cycle; the pattern is retained.
REQ-026 When clear=1 and pat_load=1 in the same cycle, SHALL perform both actions.

Reset
REQ-027 While n_rst=0, SHALL force pattern=RST_PAT, history=0, fill=0, match_count=0, o=0, count_sat=0, independent of clk.
REQ-028 SHALL resume detection on the first rising edge after n_rst releases, with no partial history carried over.
REQ-029 A reset asserted mid-sequence SHALL abort the partial match; post-release matches require PAT_W new bits.

Structure
REQ-030 SHALL place the default constants (DEF_PAT_W=4, DEF_CNT_W=8, DEF_PAT=4'b1101) in package seq_det_pkg.
REQ-031 SHALL instantiate one sub-module, sat_counter (parametrised width, sync clear, increment enable, saturation flag), for match_count.

Verification
REQ-032 Reset: n_rst=0 with i=1, i_valid=1 across a clock edge -> o=0, match_count=0; still 0 after release.
REQ-033 Overlap, default pattern: stream 1101101 (i_valid=1 throughout) -> o=1 on bits 4 and 7 only; match_count=2.
REQ-034 Non-overlap: the same 1101101 -> o=1 on bit 4 only; then 11011101 -> o=1 on bits 4 and 8; gaps with i_valid=0 mid-stream change no result.
REQ-035 Pattern load: pat_load with pat_in=4'b0110 while bit 3 of 1101 is present -> o=0 that cycle; then 0110 -> o=1 on its 4th bit; match_count retained.
REQ-036 Saturation: CNT_W=2, overlap, stream 1111111 with pattern 1111 -> match_count 1,2,3,3; count_sat=1 from the third match; clear -> count 0, count_sat=0.
REQ-037 Parametrised: PAT_W=8, RST_PAT=8'hA5, stream 0xA5A5 MSB-first -> o=1 on bits 8 and 16 (non-overlap) or bits 8 and 16 (overlap); no match on 0xA4.
